// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display path.
//   SEG7_HEX     : active-low {g,f,e,d,c,b,a} patterns for hex digits 0-F
//   seg7_decode  : nibble -> active-low segment pattern
//   idx_width    : $clog2(n) clamped to at least 1, for counter/index widths
package seg7_pkg;

    localparam logic [6:0] SEG7_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,  // 0 1 2 3
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,  // 4 5 6 7
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,  // 8 9 A b
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110   // C d E F
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        return SEG7_HEX[nib];
    endfunction

    // A one-entry range still needs a one-bit register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot and digit counters for the display scan.
//   clk, reset_n : system clock, synchronous active-low reset
//   slot         : position s inside the current digit slot, 0..REFRESH_DIV-1
//   digit_idx    : digit i being scanned, 0..N_DIGITS-1
//   frame_start  : high in the last cycle of a frame, i.e. the next edge
//                  enters (i=0, s=0)
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter  int REFRESH_DIV = 10000,
    parameter  int N_DIGITS    = 8,
    localparam int S_W         = idx_width(REFRESH_DIV),
    localparam int I_W         = idx_width(N_DIGITS)
) (
    input  logic           clk,
    input  logic           reset_n,
    output logic [S_W-1:0] slot,
    output logic [I_W-1:0] digit_idx,
    output logic           frame_start
);

    logic [S_W-1:0] s_q, s_d;
    logic [I_W-1:0] i_q, i_d;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        s_d         = s_q + 1'b1;
        i_d         = i_q;
        frame_start = 1'b0;
        if (s_q == S_W'(REFRESH_DIV - 1)) begin
            s_d = '0;
            if (i_q == I_W'(N_DIGITS - 1)) begin
                i_d         = '0;
                frame_start = 1'b1;
            end else begin
                i_d = i_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_q <= '0;
            i_q <= '0;
        end else begin
            s_q <= s_d;
            i_q <= i_d;
        end
    end

    assign slot      = s_q;
    assign digit_idx = i_q;

endmodule

// File: rtl/seg7_mux_ctrl.sv
// Time-multiplexed common-anode 7-segment controller.
//   clk, reset_n     : system clock, synchronous active-low reset
//   digits           : nibble i drives digit i (digit 0 rightmost)
//   dp_mask          : 1 = decimal point on for that digit
//   blank_mask       : 1 = digit forced dark
//   blink_mask       : 1 = digit blinks while blink_en is set
//   blink_en, lz_en  : global blink and leading-zero suppression enables
//   brightness       : lit-window length code, 0 dimmest
//   anodes           : active-low digit enables
//   cathodes, dp     : active-low segments {g,f,e,d,c,b,a} and decimal point
//   frame_tick       : one-cycle pulse in the first cycle of each frame
// All inputs are captured once per frame so the picture never tears.
module seg7_mux_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int REFRESH_DIV  = 10000,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  blink_en,
    input  logic                  lz_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [N_DIGITS-1:0]   anodes,
    output logic [6:0]            cathodes,
    output logic                  dp,
    output logic                  frame_tick
);

    localparam int S_W     = idx_width(REFRESH_DIV);
    localparam int I_W     = idx_width(N_DIGITS);
    localparam int BLINK_W = idx_width(BLINK_FRAMES);
    localparam int STEP    = REFRESH_DIV >> BRIGHT_W;

    logic [S_W-1:0] slot;
    logic [I_W-1:0] digit_idx;
    logic           frame_start;

    seg7_slot_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .N_DIGITS    (N_DIGITS)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .slot        (slot),
        .digit_idx   (digit_idx),
        .frame_start (frame_start)
    );

    // Frame snapshot
    logic [4*N_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [N_DIGITS-1:0]   snap_blank_q, snap_blank_d;
    logic [N_DIGITS-1:0]   snap_blink_mask_q, snap_blink_mask_d;
    logic                  snap_blink_en_q, snap_blink_en_d;
    logic                  snap_lz_q, snap_lz_d;
    logic [BRIGHT_W-1:0]   snap_bright_q, snap_bright_d;

    // Blink phase: toggles on every BLINK_FRAMES-th frame start.
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;

    // Output registers
    logic [N_DIGITS-1:0]   anodes_q, anodes_d;
    logic [6:0]            cathodes_q, cathodes_d;
    logic                  dp_q, dp_d;
    logic                  frame_tick_q, frame_tick_d;

    always_comb begin
        snap_digits_d     = snap_digits_q;
        snap_dp_d         = snap_dp_q;
        snap_blank_d      = snap_blank_q;
        snap_blink_mask_d = snap_blink_mask_q;
        snap_blink_en_d   = snap_blink_en_q;
        snap_lz_d         = snap_lz_q;
        snap_bright_d     = snap_bright_q;
        blink_cnt_d       = blink_cnt_q;
        phase_d           = phase_q;
        if (frame_start) begin
            snap_digits_d     = digits;
            snap_dp_d         = dp_mask;
            snap_blank_d      = blank_mask;
            snap_blink_mask_d = blink_mask;
            snap_blink_en_d   = blink_en;
            snap_lz_d         = lz_en;
            snap_bright_d     = brightness;
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Leading-zero suppression: walk down from the leftmost digit and keep
    // suppressing until the first nonzero nibble. Digit 0 is never touched.
    logic [N_DIGITS-1:0] supp;
    logic                seen_nz;

    always_comb begin
        supp    = '0;
        seen_nz = 1'b0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (snap_digits_q[4*k +: 4] != 4'h0) begin
                seen_nz = 1'b1;
            end
            supp[k] = snap_lz_q && !seen_nz;
        end
    end

    // Lit window: s=0 is the dark guard slot that stops ghosting between
    // digits; the window ends at (brightness+1)*STEP, which is REFRESH_DIV at
    // full brightness.
    logic [3:0]     cur_nib;
    logic           cur_dp;
    logic           cur_vis;
    logic [S_W:0]   lit_limit;
    logic           lit;

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_vis = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (digit_idx == I_W'(k)) begin
                cur_nib = snap_digits_q[4*k +: 4];
                cur_dp  = snap_dp_q[k];
                cur_vis = !snap_blank_q[k]
                          && !(snap_blink_en_q && snap_blink_mask_q[k] && phase_q)
                          && !supp[k];
            end
        end
        lit_limit = (S_W + 1)'((int'(snap_bright_q) + 1) * STEP);
        lit       = cur_vis && (slot != '0) && ({1'b0, slot} < lit_limit);

        anodes_d = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (lit && digit_idx == I_W'(k)) begin
                anodes_d[k] = 1'b0;
            end
        end
        cathodes_d   = lit ? seg7_decode(cur_nib) : 7'h7F;
        dp_d         = lit ? ~cur_dp : 1'b1;
        frame_tick_d = frame_start;
    end

    // NOTE: the snapshot is reset along with the control state because the
    // reset value (all digits blanked) is what keeps frame 0 dark.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_digits_q     <= '0;
            snap_dp_q         <= '0;
            snap_blank_q      <= '1;
            snap_blink_mask_q <= '0;
            snap_blink_en_q   <= 1'b0;
            snap_lz_q         <= 1'b0;
            snap_bright_q     <= '0;
            blink_cnt_q       <= '0;
            phase_q           <= 1'b0;
            anodes_q          <= '1;
            cathodes_q        <= 7'h7F;
            dp_q              <= 1'b1;
            frame_tick_q      <= 1'b0;
        end else begin
            snap_digits_q     <= snap_digits_d;
            snap_dp_q         <= snap_dp_d;
            snap_blank_q      <= snap_blank_d;
            snap_blink_mask_q <= snap_blink_mask_d;
            snap_blink_en_q   <= snap_blink_en_d;
            snap_lz_q         <= snap_lz_d;
            snap_bright_q     <= snap_bright_d;
            blink_cnt_q       <= blink_cnt_d;
            phase_q           <= phase_d;
            anodes_q          <= anodes_d;
            cathodes_q        <= cathodes_d;
            dp_q              <= dp_d;
            frame_tick_q      <= frame_tick_d;
        end
    end

    assign anodes     = anodes_q;
    assign cathodes   = cathodes_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// Bench for seg7_mux_ctrl with N_DIGITS=4, REFRESH_DIV=32, BRIGHT_W=2,
// BLINK_FRAMES=2. A time-based model predicts every output cycle; directed
// frame statistics pin the model to hand-computed values.
module tb_seg7_mux_ctrl;

    localparam int N   = 4;
    localparam int RD  = 32;
    localparam int BW  = 2;
    localparam int BF  = 2;
    localparam int FRM = N * RD;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [4*N-1:0] digits;
    logic [N-1:0]  dp_mask, blank_mask, blink_mask;
    logic          blink_en, lz_en;
    logic [BW-1:0] brightness;
    logic [N-1:0]  anodes;
    logic [6:0]    cathodes;
    logic          dp, frame_tick;

    seg7_mux_ctrl #(
        .N_DIGITS     (N),
        .REFRESH_DIV  (RD),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits     (digits),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .blink_en   (blink_en),
        .lz_en      (lz_en),
        .brightness (brightness),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int             m_n;        // cycles since reset, counter-state time
    int             m_frames;   // frame starts since reset
    logic [4*N-1:0] m_digits;
    logic [N-1:0]   m_dp, m_blank, m_bmask;
    logic           m_ben, m_lz;
    int             m_bright;
    logic           model_valid = 1'b0;
    logic [N-1:0]   exp_an;
    logic [6:0]     exp_cat;
    logic           exp_dp, exp_tick;

    function automatic logic model_visible(input int d);
        int hi;
        hi = -1;
        for (int k = 0; k < N; k++) if (m_digits[4*k +: 4] != 4'h0) hi = k;
        if (m_blank[d]) return 1'b0;
        if (m_ben && m_bmask[d] && ((m_frames / BF) % 2 == 1)) return 1'b0;
        if (m_lz && d != 0 && d > hi) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_n = 0; m_frames = 0;
            m_digits = '0; m_dp = '0; m_blank = '1; m_bmask = '0;
            m_ben = 1'b0; m_lz = 1'b0; m_bright = 0;
            exp_an = '1; exp_cat = 7'h7F; exp_dp = 1'b1; exp_tick = 1'b0;
            model_valid = 1'b1;
        end else begin
            int pos, d, s;
            logic lit;
            pos = m_n % FRM;
            d   = pos / RD;
            s   = pos % RD;
            lit = model_visible(d) && s >= 1 && s < (m_bright + 1) * (RD >> BW);
            exp_an   = lit ? ~(N'(1) << d) : '1;
            exp_cat  = lit ? hex_tab[m_digits[4*d +: 4]] : 7'h7F;
            exp_dp   = lit ? ~m_dp[d] : 1'b1;
            exp_tick = (pos == FRM - 1);
            if (pos == FRM - 1) begin
                m_digits = digits; m_dp = dp_mask; m_blank = blank_mask;
                m_bmask = blink_mask; m_ben = blink_en; m_lz = lz_en;
                m_bright = int'(brightness);
                m_frames++;
            end
            m_n++;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("cycle_model", {19'd0, anodes, cathodes, dp, frame_tick},
                  {19'd0, exp_an, exp_cat, exp_dp, exp_tick});
        end
    end

    // ---------------- directed frame statistics ----------------
    int         lit_cnt [N];
    logic [6:0] cat_seen [N];
    int         dp_lo [N];
    int         dark_cnt, tick_pos, d0_min_s, d0_max_s;

    task automatic apply(input int act);
        case (act)
            1: brightness = 2'd0;
            2: begin brightness = 2'd3; blink_en = 1'b1; blink_mask = 4'b0011; end
            3: begin blink_en = 1'b0; lz_en = 1'b1; digits = 16'h0045; end
            4: digits = 16'h0000;
            5: begin digits = 16'h89AB; dp_mask = 4'b0100; lz_en = 1'b0; end
            default: ;
        endcase
    endtask

    // Observes one full frame, starting right after a frame_tick cycle; the
    // next frame_tick must land on the last cycle of the window.
    task automatic run_frame(input int act);
        for (int k = 0; k < N; k++) begin
            lit_cnt[k] = 0; cat_seen[k] = 7'h7F; dp_lo[k] = 0;
        end
        dark_cnt = 0; tick_pos = -1; d0_min_s = RD; d0_max_s = -1;
        for (int j = 0; j < FRM; j++) begin
            @(negedge clk);
            if (anodes == '1) dark_cnt++;
            for (int k = 0; k < N; k++) begin
                if (anodes == ~(N'(1) << k)) begin
                    lit_cnt[k]++;
                    cat_seen[k] = cathodes;
                    if (!dp) dp_lo[k]++;
                    if (k == 0) begin
                        if (j % RD < d0_min_s) d0_min_s = j % RD;
                        if (j % RD > d0_max_s) d0_max_s = j % RD;
                    end
                end
            end
            if (frame_tick) tick_pos = j;
            if (j == FRM / 2) apply(act);
        end
        check("frame_len", tick_pos, FRM - 1);
    endtask

    initial begin
        int dark_err;
        reset_n = 1'b0;
        digits = 16'h1234; dp_mask = '0; blank_mask = '0; blink_mask = '0;
        blink_en = 1'b0; lz_en = 1'b0; brightness = 2'd3;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);

        // Mid-frame reset
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {19'd0, anodes, cathodes, dp, frame_tick},
                  {19'd0, 4'b1111, 7'h7F, 1'b1, 1'b0});
        end
        reset_n = 1'b1;   // this negedge lies in cycle 1 after reset

        dark_err = 0;
        for (int c = 1; c <= FRM; c++) begin
            if (c > 1) @(negedge clk);
            if (anodes != 4'b1111 || frame_tick) dark_err++;
        end
        check("frame0_dark", dark_err, 0);
        @(negedge clk);
        check("tick_at_129", frame_tick, 1);

        // Frame 1: brightness 3, 16'h1234
        run_frame(1);
        check("f1_d0_lit", lit_cnt[0], 31);
        check("f1_d0_cat", cat_seen[0], 7'b0011001);
        check("f1_d3_lit", lit_cnt[3], 31);
        check("f1_d3_cat", cat_seen[3], 7'b1111001);
        check("f1_guard_dark", dark_cnt, 4);

        // Frame 2: brightness 0
        run_frame(2);
        for (int k = 0; k < N; k++) check("f2_lit7", lit_cnt[k], 7);
        check("f2_first_s", d0_min_s, 1);
        check("f2_last_s", d0_max_s, 7);

        // Frames 3..6: blink on digits 0,1 (phase 1,0,0,1)
        run_frame(0);
        check("f3_d0_blink_off", lit_cnt[0], 0);
        check("f3_d1_blink_off", lit_cnt[1], 0);
        check("f3_d2_on", lit_cnt[2], 31);
        run_frame(0);
        check("f4_d0_on", lit_cnt[0], 31);
        run_frame(0);
        check("f5_d1_on", lit_cnt[1], 31);
        run_frame(3);
        check("f6_d0_blink_off", lit_cnt[0], 0);
        check("f6_d3_on", lit_cnt[3], 31);

        // Frame 7: lz with 16'h0045
        run_frame(4);
        check("f7_d3_supp", lit_cnt[3], 0);
        check("f7_d2_supp", lit_cnt[2], 0);
        check("f7_d1_cat", cat_seen[1], 7'b0011001);
        check("f7_d0_cat", cat_seen[0], 7'b0010010);

        // Frame 8: lz with 16'h0000
        run_frame(0);
        check("f8_d0_lit", lit_cnt[0], 31);
        check("f8_d0_cat", cat_seen[0], 7'b1000000);
        check("f8_others_dark", lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);

        // Frame 9: inputs change mid-frame, picture must not change
        run_frame(5);
        check("f9_d0_unchanged", cat_seen[0], 7'b1000000);
        check("f9_others_dark", lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);
        check("f9_no_dp", dp_lo[0] + dp_lo[1] + dp_lo[2] + dp_lo[3], 0);

        // Frame 10: new snapshot 16'h89AB, dp on digit 2
        run_frame(0);
        check("f10_d2_cat", cat_seen[2], 7'b0010000);
        check("f10_d0_cat", cat_seen[0], 7'b0000011);
        check("f10_dp_d2", dp_lo[2], 31);
        check("f10_dp_other", dp_lo[0] + dp_lo[1] + dp_lo[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_mux_ctrl.md
# seg7_mux_ctrl

Parametrised, time-multiplexed 7-segment display controller for the alarm-clock display path. It drives N_DIGITS common-anode digits from a packed hex/BCD vector and adds features the fixed 6-digit controller lacks:
- per-digit decimal point, blanking and blink masks;
- leading-zero suppression and PWM brightness;
- a ghosting guard cycle;
- tear-free frame snapshots.

It runs entirely on the system clock using internal enables; there is no derived clock.

## Interface
Parameters:
- N_DIGITS, 8, number of digits (1..16)
- REFRESH_DIV, 10000, clk cycles per digit slot; must be a multiple of 2**BRIGHT_W and ≥ 2*2**BRIGHT_W
- BRIGHT_W, 4, brightness code width
- BLINK_FRAMES, 250, frames per blink half-period (≥1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock, synchronous, active-low
- digits  in  4*N_DIGITS  nibble i drives digit i; digit 0 is rightmost
- dp_mask  in  N_DIGITS  1 = decimal point on
- blank_mask  in  N_DIGITS  1 = digit forced dark
- blink_mask  in  N_DIGITS  1 = digit blinks when blink_en=1
- blink_en  in  1  global blink enable
- lz_en  in  1  leading-zero suppression enable
- brightness  in  BRIGHT_W  0 = dimmest, all-ones = brightest
- anodes  out  N_DIGITS  active-low digit enables
- cathodes  out  7  active-low segments {g,f,e,d,c,b,a}
- dp  out  1  active-low decimal point
- frame_tick  out  1  one-cycle pulse at each frame start

## Operation
- Counters:
  - slot counter s runs 0..REFRESH_DIV-1.
  - When s wraps, digit index i advances 0..N_DIGITS-1 and then wraps to 0.
  - Frame start is the edge that enters (i=0, s=0).
- Snapshot:
  - At every frame-start edge, all inputs except reset_n are registered.
  - All display decisions use only snapshot values, so input changes mid-frame have no effect until the next frame.
- Blink phase:
  - Toggles after every BLINK_FRAMES frame starts.
  - Reset value is 0 (visible).
- Leading-zero suppression:
  - Applies when snapshot lz_en=1.
  - Suppressed digits are the zero nibbles from digit N_DIGITS-1 downward, up to but excluding the first nonzero nibble.
  - Digit 0 is never suppressed.
- Visibility: digit i is visible iff all of the following hold:
  - blank_mask[i]=0;
  - not (blink_en and blink_mask[i] and phase=1);
  - not suppressed.
- Lit window:
  - STEP = REFRESH_DIV >> BRIGHT_W.
  - Digit i is lit iff visible and 1 ≤ s < (brightness+1)*STEP.
  - s=0 is always dark; this is the ghosting guard.
- Outputs while lit:
  - anodes[i]=0; all other anodes are 1.
  - cathodes = hex encoding of nibble i (0-F all defined).
  - dp = ~dp_mask[i].
- Outputs while not lit: anodes all 1, cathodes 7'h7F, dp 1.
- Example encodings: 0→7'b1000000, 4→7'b0011001, 8→7'b0000000, F→7'b0001110.

## Timing
- All outputs are registered. They reflect the counter state of the previous cycle, giving 1-cycle latency.
- frame_tick is high in the cycle immediately after the frame-start edge.
- Reset (reset_n=0 at any edge, including mid-frame) sets:
  - s=0, i=0, phase=0;
  - snapshot blank_mask all ones and other snapshot fields 0;
  - anodes all 1, cathodes 7'h7F, dp 1, frame_tick 0.
- Frame 0 after reset is therefore fully dark. The first snapshot is taken at the end of frame 0.
- Frame length is exactly N_DIGITS*REFRESH_DIV cycles.
- A blink toggle and a snapshot at the same frame start both take effect for the new frame.

## Structure
- Package seg7_pkg holds:
  - the 16-entry active-low SEG7_HEX constant array (type logic [6:0]);
  - function seg7_decode;
  - a localparam helper for the index width, $clog2(N_DIGITS) with a minimum of 1.
- One sub-module, seg7_slot_timer, holds the s and i counters and generates the frame-start strobe.
- The top level contains the snapshot, blink, suppression and lit-window logic, plus the output registers.

## Test plan
Test configuration: N_DIGITS=4, REFRESH_DIV=32, BRIGHT_W=2 (STEP=8), BLINK_FRAMES=2.
- Reset:
  - Stimulus: reset_n low for 3 cycles mid-frame, then release.
  - Required: outputs are 1/7'h7F/1/0 during reset; the first 128 cycles are dark; frame_tick fires at cycle 129.
- Brightness 3, full digits:
  - Stimulus: digits=16'h1234, brightness=3.
  - Required: in frame 1, anodes=4'b1110 with cathodes=7'b0011001 for 31 of 32 slot cycles; the guard cycle is dark.
- Brightness 0:
  - Stimulus: brightness=0.
  - Required: each digit is lit for exactly 7 cycles per slot (s=1..7).
- Blink:
  - Stimulus: blink_en=1, blink_mask=4'b0011.
  - Required: digits 0 and 1 are dark in frames where phase=1 and show in phase=0 frames; the phase alternates every 2 frames.
- Leading-zero suppression:
  - Stimulus: lz_en=1 with digits=16'h0045.
  - Required: digits 3 and 2 are dark.
  - Stimulus: digits=16'h0000.
  - Required: only digit 0 shows 7'b1000000.
- Snapshot and decimal point:
  - Stimulus: change digits and dp_mask=4'b0100 mid-frame.
  - Required: displayed values are unchanged until after the next frame_tick; then dp=0 only during digit 2's lit window.
